// File: rtl/engine_reg_bus_pkg.sv
// Shared types and defaults for the EngineTEST controlling-register bus master.
package engine_reg_bus_pkg;

  localparam int unsigned ADDR_W_DEF       = 33;
  localparam int unsigned WDATA_W_DEF      = 33;
  localparam int unsigned RDATA_W_DEF      = 21;
  localparam int unsigned READ_LATENCY_MAX = 7;
  localparam int unsigned LAT_CNT_W        = 3;

  typedef enum logic [1:0] {
    IDLE,
    WR_STROBE,
    RD_STROBE,
    RESP
  } state_e;

  // Start value of the read-strobe down-counter; out-of-range latencies saturate.
  function automatic logic [LAT_CNT_W-1:0] lat_count_init(input int unsigned lat);
    if (lat > READ_LATENCY_MAX) begin
      return LAT_CNT_W'(READ_LATENCY_MAX);
    end
    return LAT_CNT_W'(lat);
  endfunction

endpackage

// File: rtl/engine_reg_bus_master_if.sv
// Command, response and register-bus signals of engine_reg_bus_master.
interface engine_reg_bus_master_if #(
  parameter int unsigned ADDR_W  = engine_reg_bus_pkg::ADDR_W_DEF,
  parameter int unsigned WDATA_W = engine_reg_bus_pkg::WDATA_W_DEF,
  parameter int unsigned RDATA_W = engine_reg_bus_pkg::RDATA_W_DEF
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [WDATA_W-1:0] cmd_wdata;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_write;
  logic [RDATA_W-1:0] rsp_rdata;
  logic               rsp_error;

  logic [ADDR_W-1:0]  address;
  logic               write_enable;
  logic [WDATA_W-1:0] write_data;
  logic               read_enable;
  logic [RDATA_W-1:0] read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, read_data,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
    output address, write_enable, write_data, read_enable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, read_data,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
    input  address, write_enable, write_data, read_enable
  );

endinterface

// File: rtl/engine_reg_bus_master.sv
// Register-bus initiator: one command in flight, strobes the bus, returns one response.
// Optional write read-back check: ENGINE_REG_BUS_MASTER_WRITE_VERIFY_EN.
module engine_reg_bus_master
  import engine_reg_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned WDATA_W      = WDATA_W_DEF,
  parameter int unsigned RDATA_W      = RDATA_W_DEF,
  parameter int unsigned READ_LATENCY = 0
) (
  input logic                    clock,
  input logic                    reset,
  engine_reg_bus_master_if.master bus
);

  localparam logic [LAT_CNT_W-1:0] LatInit = lat_count_init(READ_LATENCY);

  state_e               state_q;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 is_write_q;
  logic [ADDR_W-1:0]    address_q;
  logic [WDATA_W-1:0]   write_data_q;
  logic                 write_enable_q;
  logic                 read_enable_q;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_write_q;
  logic [RDATA_W-1:0]   rsp_rdata_q;
`ifdef ENGINE_REG_BUS_MASTER_WRITE_VERIFY_EN
  logic                 rsp_error_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      lat_cnt_q      <= '0;
      is_write_q     <= 1'b0;
      address_q      <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
`ifdef ENGINE_REG_BUS_MASTER_WRITE_VERIFY_EN
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            is_write_q  <= bus.cmd_write;
            address_q   <= bus.cmd_addr;
            if (bus.cmd_write) begin
              write_data_q   <= bus.cmd_wdata;
              write_enable_q <= 1'b1;
              state_q        <= WR_STROBE;
            end else begin
              read_enable_q <= 1'b1;
              lat_cnt_q     <= LatInit;
              state_q       <= RD_STROBE;
            end
          end else begin
            // Raises ready one cycle after reset release.
            cmd_ready_q <= 1'b1;
          end
        end

        WR_STROBE: begin
          write_enable_q <= 1'b0;
`ifdef ENGINE_REG_BUS_MASTER_WRITE_VERIFY_EN
          read_enable_q  <= 1'b1;
          lat_cnt_q      <= LatInit;
          state_q        <= RD_STROBE;
`else
          rsp_valid_q    <= 1'b1;
          rsp_write_q    <= 1'b1;
          rsp_rdata_q    <= '0;
          state_q        <= RESP;
`endif
        end

        RD_STROBE: begin
          if (lat_cnt_q == '0) begin
            read_enable_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= is_write_q;
            rsp_rdata_q   <= bus.read_data;
`ifdef ENGINE_REG_BUS_MASTER_WRITE_VERIFY_EN
            rsp_error_q   <= is_write_q && (bus.read_data != write_data_q[RDATA_W-1:0]);
`endif
            state_q       <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.address      = address_q;
  assign bus.write_enable = write_enable_q;
  assign bus.write_data   = write_data_q;
  assign bus.read_enable  = read_enable_q;
`ifdef ENGINE_REG_BUS_MASTER_WRITE_VERIFY_EN
  assign bus.rsp_error    = rsp_error_q;
`else
  assign bus.rsp_error    = 1'b0;
`endif

endmodule
